fht_adc_loader: RTL and testbench
=================================

Name: fht_adc_loader

Overview:
- Upstream feeder for fht_top.
- Takes a free-running ADC sample stream and sign-extends each sample to the FHT data width.
- Writes one frame of 4*BANK_SIZE samples into the four FHT RAM banks, bank-interleaved, then pulses the FHT start input and waits for the transform to finish.
- The ADC cannot be stalled; samples arriving while the FHT is busy are dropped and counted.

Parameters:
- ADC_WIDTH, 12: width of the raw signed ADC sample.
- D_BIT, 18: FHT data width; must be >= ADC_WIDTH.
- A_BIT, 8: per-bank address width.
- BANK_SIZE, 256: words per bank; must equal 2**A_BIT.
- DROP_W, 16: width of the dropped-sample counter.

Ports:
- iCLK  in  1  system clock.
- iRESET  in  1  synchronous, active-high reset.
- iEN  in  1  loader enable; while low, no new frame is started.
- iADC_VALID  in  1  one-cycle strobe qualifying iADC_DATA.
- iADC_DATA  in  ADC_WIDTH  signed two's-complement sample.
- iFHT_RDY  in  1  fht_top oRDY.
- oWE  out  4  one-hot bank write enable (fht_top iWE).
- oDATA  out  D_BIT  write data, shared by fht_top iDATA_0..3.
- oADDR_WR  out  A_BIT  write address, shared by iADDR_WR_0..3.
- oSTART  out  1  single-cycle FHT start pulse.
- oLOADING  out  1  high while in LOAD state.
- oFRAME_DONE  out  1  single-cycle pulse when the FHT completes a frame.
- oDROP_CNT  out  DROP_W  saturating count of dropped samples.

Behaviour:
- Reset (synchronous, iRESET=1):
  - State goes to LOAD; sample index n=0.
  - oWE=0, oDATA=0, oADDR_WR=0, oSTART=0, oFRAME_DONE=0, oDROP_CNT=0.
  - oLOADING=1 after reset, but no sample is accepted while iEN=0.
  - Reset mid-frame discards the partial frame; banks are not cleared.
- States:
  - LOAD: accept samples while iEN=1. After the sample with n=4*BANK_SIZE-1 is accepted, go to FLUSH.
  - FLUSH: one cycle, lets the final write retire. Then go to START.
  - START: oSTART=1 for exactly one cycle. Then go to WAIT_LOW.
  - WAIT_LOW: wait for iFHT_RDY=0. Then go to WAIT_HIGH.
  - WAIT_HIGH: wait for iFHT_RDY=1. Then pulse oFRAME_DONE for one cycle, set n=0, and go to LOAD.
- Accept condition: iADC_VALID=1 and state=LOAD and iEN=1.
- Accepted sample, index n (0..4*BANK_SIZE-1):
  - Bank b = n[1:0]; address = n[A_BIT+1:2].
  - Registered outputs on the next edge (latency 1): oWE = 1<<b, oADDR_WR = address, oDATA = iADC_DATA sign-extended to D_BIT.
  - oWE=0 in every cycle without an accepted sample. oDATA and oADDR_WR hold their last value.
- Drop condition: iADC_VALID=1 and the sample is not accepted (any non-LOAD state, or iEN=0).
  - oDROP_CNT increments by 1 and saturates at 2**DROP_W-1.
  - Only reset clears it.
- iEN falling mid-frame: loading pauses; n and the bank contents are retained. Loading resumes when iEN returns high.
- Wrap-around: n rolls from 4*BANK_SIZE-1 to 0 only via WAIT_HIGH → LOAD, never inside LOAD.
- WAIT_LOW exists because iFHT_RDY may still be high for 1-2 cycles after oSTART. No timeout.
- Simultaneous events in WAIT_HIGH: if iFHT_RDY=1 and iADC_VALID=1 in the same cycle, the sample is dropped. The first accepted sample of the next frame is the one arriving in the first LOAD cycle.

Optional Feature:
- Macro: FHT_LOADER_BITREV_EN.
- Defined: the frame index n is bit-reversed over A_BIT+2 bits before the bank/address split. Bank = rev(n)[1:0], address = rev(n)[A_BIT+1:2]. Data is delivered to the FHT in bit-reversed order.
- Undefined: natural order, as specified in Behaviour. Bit-reversal is then handled elsewhere.

Test Plan:
- Reset, iEN=1, valid samples 0x001,0x002,0x003,0x004 on consecutive cycles → one cycle later:
  - oWE = 0001,0010,0100,1000;
  - oADDR_WR = 0,0,0,0;
  - oDATA = 1,2,3,4.
  - 5th sample → oWE=0001, oADDR_WR=1.
- Sample 0x800 (ADC_WIDTH=12) → oDATA=0x3F800 (D_BIT=18). Sample 0x7FF → oDATA=0x007FF.
- Full frame of 1024 samples → after the last write:
  - one FLUSH cycle, then oSTART high for exactly 1 cycle;
  - with iFHT_RDY 0 for 50 cycles then 1 → oFRAME_DONE 1-cycle pulse; oLOADING returns to 1.
- 30 valid strobes during WAIT_LOW/WAIT_HIGH → oDROP_CNT=30; oWE stays 0. With DROP_W=4, 20 drops → oDROP_CNT=15.
- iEN low after 100 samples, 10 valid strobes, iEN high, 924 more samples → oDROP_CNT=10; oSTART fires after 1024 accepted samples.
- iRESET asserted at n=500 → next cycle all outputs 0, oLOADING=1; next accepted sample goes to oWE=0001, oADDR_WR=0. With FHT_LOADER_BITREV_EN: n=1 → bank 0, address 128.

Source files
------------

// File: rtl/fht_adc_loader.sv
// rtl/fht_adc_loader.sv - ADC sample loader feeding fht_top's four RAM banks, then triggering the transform.
// Optional FHT_LOADER_BITREV_EN: scatter the frame in bit-reversed index order.
module fht_adc_loader #(
  parameter int ADC_WIDTH = 12,
  parameter int D_BIT     = 18,
  parameter int A_BIT     = 8,
  parameter int BANK_SIZE = 256,
  parameter int DROP_W    = 16
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iEN,
  input  logic                 iADC_VALID,
  input  logic [ADC_WIDTH-1:0] iADC_DATA,
  input  logic                 iFHT_RDY,
  output logic [3:0]           oWE,
  output logic [D_BIT-1:0]     oDATA,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic                 oSTART,
  output logic                 oLOADING,
  output logic                 oFRAME_DONE,
  output logic [DROP_W-1:0]    oDROP_CNT
);

  localparam int NW = A_BIT + 2;
  localparam logic [NW-1:0] N_LAST = NW'(4 * BANK_SIZE - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FLUSH,
    S_START,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  state_t        state;
  logic [NW-1:0] n;
  logic [NW-1:0] idx;
  logic          accept;
  logic          drop;

`ifdef FHT_LOADER_BITREV_EN
  function automatic logic [NW-1:0] bit_rev(input logic [NW-1:0] v);
    logic [NW-1:0] r;
    for (int i = 0; i < NW; i++) r[i] = v[NW-1-i];
    return r;
  endfunction
  assign idx = bit_rev(n);
`else
  assign idx = n;
`endif

  assign accept   = iADC_VALID && (state == S_LOAD) && iEN;
  assign drop     = iADC_VALID && !accept;
  assign oLOADING = (state == S_LOAD);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state       <= S_LOAD;
      n           <= '0;
      oWE         <= '0;
      oDATA       <= '0;
      oADDR_WR    <= '0;
      oSTART      <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oDROP_CNT   <= '0;
    end else begin
      oWE         <= '0;
      oSTART      <= 1'b0;
      oFRAME_DONE <= 1'b0;

      if (drop && (oDROP_CNT != {DROP_W{1'b1}}))
        oDROP_CNT <= oDROP_CNT + 1'b1;

      // Data and address hold between writes; only the enable is strobed.
      if (accept) begin
        oWE      <= 4'b0001 << idx[1:0];
        oADDR_WR <= idx[NW-1:2];
        oDATA    <= D_BIT'($signed(iADC_DATA));
      end

      case (state)
        S_LOAD: begin
          if (accept) begin
            if (n == N_LAST) state <= S_FLUSH;
            else             n     <= n + 1'b1;
          end
        end
        S_FLUSH: begin
          state  <= S_START;
          oSTART <= 1'b1;
        end
        S_START: state <= S_WAIT_LOW;
        // The FHT may keep reporting ready for a couple of cycles after the start pulse.
        S_WAIT_LOW: if (!iFHT_RDY) state <= S_WAIT_HIGH;
        S_WAIT_HIGH: begin
          if (iFHT_RDY) begin
            state       <= S_LOAD;
            n           <= '0;
            oFRAME_DONE <= 1'b1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_adc_loader.sv
// tb/tb_fht_adc_loader.sv - directed vector bench for fht_adc_loader.
module tb_fht_adc_loader;

  logic        clk = 1'b0;
  logic        rst, en, valid, rdy;
  logic [11:0] data;
  logic [3:0]  we, we4;
  logic [17:0] dout, dout4;
  logic [7:0]  addr, addr4;
  logic        start, start4, loading, loading4, done, done4;
  logic [15:0] drop;
  logic [3:0]  drop4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fht_adc_loader dut (
    .iCLK(clk), .iRESET(rst), .iEN(en), .iADC_VALID(valid), .iADC_DATA(data),
    .iFHT_RDY(rdy), .oWE(we), .oDATA(dout), .oADDR_WR(addr), .oSTART(start),
    .oLOADING(loading), .oFRAME_DONE(done), .oDROP_CNT(drop)
  );

  fht_adc_loader #(.DROP_W(4)) dut4 (
    .iCLK(clk), .iRESET(rst), .iEN(en), .iADC_VALID(valid), .iADC_DATA(data),
    .iFHT_RDY(rdy), .oWE(we4), .oDATA(dout4), .oADDR_WR(addr4), .oSTART(start4),
    .oLOADING(loading4), .oFRAME_DONE(done4), .oDROP_CNT(drop4)
  );

  typedef struct {
    logic        valid;
    logic [11:0] data;
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [17:0] dout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] exp_idx(input int n);
    logic [9:0] v, r;
    v = 10'(n);
`ifdef FHT_LOADER_BITREV_EN
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
`else
    r = v;
`endif
    return r;
  endfunction

  function automatic logic [11:0] pat(input int n);
    return 12'(n * 37 + 5);
  endfunction

  task automatic feed(input int n, input string name);
    logic [9:0]  ix;
    logic [11:0] d;
    d = pat(n);
    valid = 1'b1;
    data = d;
    ix = exp_idx(n);
    tick();
    chk({name, "_we"}, 32'(we), 32'(4'b0001 << ix[1:0]));
    chk({name, "_addr"}, 32'(addr), 32'(ix[9:2]));
    chk({name, "_data"}, 32'(dout), 32'({{6{d[11]}}, d}));
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_we0"}, 32'(we), 32'd0);
    chk({name, "_data0"}, 32'(dout), 32'd0);
    chk({name, "_addr0"}, 32'(addr), 32'd0);
    chk({name, "_start0"}, 32'(start), 32'd0);
    chk({name, "_done0"}, 32'(done), 32'd0);
    chk({name, "_drop0"}, 32'(drop), 32'd0);
    chk({name, "_loading1"}, 32'(loading), 32'd1);
  endtask

  initial begin
`ifdef FHT_LOADER_BITREV_EN
    vecs[0] = '{1'b1, 12'h001, 4'b0001, 8'd0,   18'h00001};
    vecs[1] = '{1'b1, 12'h002, 4'b0001, 8'd128, 18'h00002};
    vecs[2] = '{1'b1, 12'h003, 4'b0001, 8'd64,  18'h00003};
    vecs[3] = '{1'b1, 12'h004, 4'b0001, 8'd192, 18'h00004};
    vecs[4] = '{1'b1, 12'h800, 4'b0001, 8'd32,  18'h3F800};
    vecs[5] = '{1'b0, 12'h000, 4'b0000, 8'd32,  18'h3F800};
    vecs[6] = '{1'b1, 12'h7FF, 4'b0001, 8'd160, 18'h007FF};
    vecs[7] = '{1'b1, 12'hFFF, 4'b0001, 8'd96,  18'h3FFFF};
    vecs[8] = '{1'b1, 12'h123, 4'b0001, 8'd224, 18'h00123};
    vecs[9] = '{1'b1, 12'h555, 4'b0001, 8'd16,  18'h00555};
`else
    vecs[0] = '{1'b1, 12'h001, 4'b0001, 8'd0, 18'h00001};
    vecs[1] = '{1'b1, 12'h002, 4'b0010, 8'd0, 18'h00002};
    vecs[2] = '{1'b1, 12'h003, 4'b0100, 8'd0, 18'h00003};
    vecs[3] = '{1'b1, 12'h004, 4'b1000, 8'd0, 18'h00004};
    vecs[4] = '{1'b1, 12'h800, 4'b0001, 8'd1, 18'h3F800};
    vecs[5] = '{1'b0, 12'h000, 4'b0000, 8'd1, 18'h3F800};
    vecs[6] = '{1'b1, 12'h7FF, 4'b0010, 8'd1, 18'h007FF};
    vecs[7] = '{1'b1, 12'hFFF, 4'b0100, 8'd1, 18'h3FFFF};
    vecs[8] = '{1'b1, 12'h123, 4'b1000, 8'd1, 18'h00123};
    vecs[9] = '{1'b1, 12'h555, 4'b0001, 8'd2, 18'h00555};
`endif

    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0; rdy = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk("en_low_idle_we", 32'(we), 32'd0);

    // First nine samples (n=0..8) plus one idle cycle, from the table.
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid = vecs[i].valid;
      data  = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_data", i), 32'(dout), 32'(vecs[i].dout));
    end

    for (int n = 9; n < 100; n++) feed(n, $sformatf("s%0d", n));

    // Pause: strobes while disabled are dropped, frame position kept.
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1;
      data = 12'h0FF;
      tick();
      chk("pause_we", 32'(we), 32'd0);
    end
    chk("pause_drop", 32'(drop), 32'd10);
    chk("pause_drop4", 32'(drop4), 32'd10);
    chk("pause_loading", 32'(loading), 32'd1);

    en = 1'b1;
    for (int n = 100; n < 1024; n++) begin
      feed(n, $sformatf("s%0d", n));
      chk("no_early_start", 32'(start), 32'd0);
    end

    valid = 1'b0;
    tick();
    chk("start_pulse", 32'(start), 32'd1);
    chk("start_we", 32'(we), 32'd0);
    chk("start_loading", 32'(loading), 32'd0);

    // rdy lingers high 2 cycles, then busy for 50; 30 strobes dropped meanwhile.
    for (int i = 0; i < 52; i++) begin
      rdy = (i < 2);
      valid = (i < 30);
      tick();
      chk("wait_start", 32'(start), 32'd0);
      chk("wait_we", 32'(we), 32'd0);
      chk("wait_done", 32'(done), 32'd0);
    end
    chk("wait_drop", 32'(drop), 32'd40);

    // Ready and a strobe together in WAIT_HIGH: that strobe is dropped.
    rdy = 1'b1;
    valid = 1'b1;
    data = 12'h00A;
    tick();
    chk("frame_done", 32'(done), 32'd1);
    chk("done_loading", 32'(loading), 32'd1);
    chk("done_we", 32'(we), 32'd0);
    chk("done_drop", 32'(drop), 32'd41);
    chk("done_drop4_sat", 32'(drop4), 32'd15);

    for (int n = 0; n < 500; n++) begin
      feed(n, $sformatf("f2_%0d", n));
      if (n == 0) chk("done_one_cycle", 32'(done), 32'd0);
    end

    // Reset mid-frame at n=500.
    valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_idle("midreset");
    chk("midreset_drop4", 32'(drop4), 32'd0);
    rst = 1'b0;
    feed(0, "after_reset_n0");
    feed(1, "after_reset_n1");
    valid = 1'b0;
    tick();
    chk("final_we_idle", 32'(we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
